// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential binary-to-BCD converter (double-dabble).
// Converts one input bit per clock: IN_WIDTH shift cycles plus one DONE cycle.
// Optional leading-zero blanking output is enabled by the macro
// LEADING_ZERO_BLANK_EN; when undefined, blank_mask is tied to zero.
module bcd_convert_seq #(
  parameter int IN_WIDTH = 20,
  parameter int DIGITS   = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                r_state;
  logic [IN_WIDTH-1:0]   r_shift;
  logic [4*DIGITS-1:0]   r_work;
  logic                  r_work_ovf;
  logic [CW-1:0]         r_cnt;
  logic                  r_in_ready;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_out_valid;
  logic                  r_ovf;
  logic [4*DIGITS-1:0]   w_adj;

  // Add-3 correction on every work digit >= 5, using pre-shift digit values.
  always_comb begin
    w_adj = r_work;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      end
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_work      <= '0;
      r_work_ovf  <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift    <= bin_in;
            r_work     <= '0;
            r_work_ovf <= 1'b0;
            r_cnt      <= CW'(IN_WIDTH);
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_work     <= {w_adj[4*DIGITS-2:0], r_shift[IN_WIDTH-1]};
          r_shift    <= r_shift << 1;
          r_work_ovf <= r_work_ovf | w_adj[4*DIGITS-1];
          r_cnt      <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_bcd       <= r_work;
          r_ovf       <= r_work_ovf;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign bcd_out   = r_bcd;
  assign out_valid = r_out_valid;
  assign overflow  = r_ovf;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_above;

  // Blank digit i (i>0) when it and every higher digit are zero.
  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int unsigned k = 1; k < DIGITS; k++) begin
      w_zero_above           = w_zero_above & (r_work[4*(DIGITS-k) +: 4] == 4'd0);
      w_blank[DIGITS-k]      = w_zero_above;
    end
  end

  // Blank mask is captured on the DONE edge together with bcd_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= '0;
    end else if (r_state == DONE) begin
      r_blank <= w_blank;
    end
  end

  assign blank_mask = r_blank;
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: a default-sized instance and a
// 3-digit instance share the same stimulus; results are compared against a
// decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bcd_convert_seq;

  localparam int IW = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [IW-1:0] bin_in;
  logic        in_valid;
  logic        in_ready, in_ready3;
  logic [27:0] bcd_out;
  logic [11:0] bcd_out3;
  logic        out_valid, out_valid3;
  logic        overflow, overflow3;
  logic [6:0]  blank_mask;
  logic [2:0]  blank_mask3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_convert_seq #(.IN_WIDTH(IW), .DIGITS(7)) u_dut (
    .clk(clk), .reset(reset), .bin_in(bin_in), .in_valid(in_valid),
    .in_ready(in_ready), .bcd_out(bcd_out), .out_valid(out_valid),
    .overflow(overflow), .blank_mask(blank_mask)
  );

  bcd_convert_seq #(.IN_WIDTH(IW), .DIGITS(3)) u_dut3 (
    .clk(clk), .reset(reset), .bin_in(bin_in), .in_valid(in_valid),
    .in_ready(in_ready3), .bcd_out(bcd_out3), .out_valid(out_valid3),
    .overflow(overflow3), .blank_mask(blank_mask3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain decimal arithmetic.
  function automatic logic [63:0] ref_bcd(input int unsigned v, input int unsigned d);
    logic [63:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int unsigned pow10(input int unsigned d);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int unsigned d);
    return v >= pow10(d);
  endfunction

  // Digits at or above the count of significant digits are blanked.
  function automatic logic [63:0] ref_blank(input int unsigned v, input int unsigned d);
    logic [63:0] m;
    int unsigned t, n;
    m = '0;
`ifdef LEADING_ZERO_BLANK_EN
    t = v % pow10(d);
    n = 1;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    for (int unsigned i = n; i < d; i++) m[i] = 1'b1;
`else
    t = v;
    n = d;
`endif
    return m;
  endfunction

  task automatic check_result(input string tag, input int unsigned v);
    check({tag, ".bcd"}, 64'(bcd_out), ref_bcd(v, 7));
    check({tag, ".ovf"}, 64'(overflow), 64'(ref_ovf(v, 7)));
    check({tag, ".blank"}, 64'(blank_mask), ref_blank(v, 7));
    check({tag, ".bcd3"}, 64'(bcd_out3), ref_bcd(v, 3));
    check({tag, ".ovf3"}, 64'(overflow3), 64'(ref_ovf(v, 3)));
    check({tag, ".blank3"}, 64'(blank_mask3), ref_blank(v, 3));
    check({tag, ".ov3sync"}, 64'(out_valid3), 64'(1));
  endtask

  // Wait (at negedge) until the converter is idle, bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({tag, ".ready_timeout"}, 64'(in_ready), 64'(1));
  endtask

  // Single isolated conversion with latency and hold checks.
  task automatic run_one(input string tag, input int unsigned v);
    int cyc;
    logic [27:0] held;
    wait_ready(tag);
    bin_in   = IW'(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin_in   = IW'($urandom);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(22));
    check({tag, ".ready_with_valid"}, 64'(in_ready), 64'(1));
    check_result(tag, v);
    held = bcd_out;
    @(negedge clk);
    check({tag, ".pulse"}, 64'(out_valid), 64'(0));
    check({tag, ".hold"}, 64'(bcd_out), 64'(held));
  endtask

  int unsigned vals[$];
  int unsigned expq[$];

  initial begin
    int unsigned v;
    int idx, cyc, last_acc, budget, quiet;
    reset    = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'(1));
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.bcd", 64'(bcd_out), 64'(0));
    check("rst.ovf", 64'(overflow), 64'(0));
    check("rst.blank", 64'(blank_mask), 64'(0));

    // Directed values and boundaries.
    run_one("zero", 0);
    run_one("v255", 255);
    run_one("vmax", 1048575);
    run_one("v1000", 1000);
    run_one("v999", 999);
    run_one("v205", 205);
    run_one("v999999", 999999);
    run_one("v1000000", 1000000);
    run_one("zero2", 0);

    // Randomized values.
    for (int i = 0; i < 25; i++) begin
      run_one("rand", $urandom_range(0, (1 << IW) - 1));
    end

    // Back-to-back sweep of every miniALU result (sum and product of nibbles).
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) vals.push_back(a + b);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) vals.push_back(a * b);
    wait_ready("b2b");
    idx = 0;
    cyc = 0;
    last_acc = -1;
    budget = 0;
    while ((idx < vals.size() || expq.size() != 0) && budget < 15000) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("b2b.spurious_valid", 64'(out_valid), 64'(0));
        end else begin
          v = expq.pop_front();
          check_result("b2b", v);
        end
      end
      if (in_ready && idx < vals.size()) begin
        bin_in   = IW'(vals[idx]);
        in_valid = 1'b1;
        expq.push_back(vals[idx]);
        idx++;
        if (last_acc >= 0) check("b2b.spacing", 64'(cyc - last_acc), 64'(22));
        last_acc = cyc;
      end else if (!in_ready) begin
        if (idx == vals.size()) in_valid = 1'b0;
        bin_in = IW'($urandom);
      end
      @(negedge clk);
      cyc++;
      budget++;
    end
    in_valid = 1'b0;
    check("b2b.drained", 64'(expq.size()), 64'(0));

    // Request while busy is ignored; bin_in changes during SHIFT have no effect.
    wait_ready("busy");
    bin_in   = IW'(1234);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_in = IW'(9999);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      check("busy.in_ready_low", 64'(in_ready), 64'(0));
      check("busy.no_valid", 64'(out_valid), 64'(0));
      bin_in = (c % 2 == 0) ? IW'(9999) : IW'($urandom);
      if (c == 21) in_valid = 1'b0;
    end
    @(negedge clk);
    check("busy.valid", 64'(out_valid), 64'(1));
    check_result("busy", 1234);
    @(negedge clk);
    check("busy.not_queued", 64'(in_ready), 64'(1));

    // Reset mid-conversion aborts with no result.
    wait_ready("abort");
    bin_in   = IW'(500);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort.in_ready", 64'(in_ready), 64'(1));
    check("abort.out_valid", 64'(out_valid), 64'(0));
    check("abort.bcd", 64'(bcd_out), 64'(0));
    check("abort.ovf", 64'(overflow), 64'(0));
    quiet = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) quiet = 0;
    end
    check("abort.no_result", 64'(quiet), 64'(1));
    run_one("after_abort", 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (add-3, then shift), one bit per clock.
- Sits directly downstream of miniALU. Consumes its 20-bit result and produces packed BCD digits for the seven-segment display driver.
- Uses a valid/ready input handshake and a one-cycle done pulse. The result is held until the next conversion completes.

Parameters:
- IN_WIDTH, 20: width of the binary input.
- DIGITS, 7: number of BCD output digits. Output width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bin_in  input  IN_WIDTH  unsigned binary value (miniALU result).
- in_valid  input  1  request to convert bin_in.
- in_ready  output  1  block is idle and can accept a value.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) is in bits [3:0].
- out_valid  output  1  one-cycle pulse: bcd_out/overflow updated.
- overflow  output  1  value did not fit in DIGITS digits; sticky until the next out_valid.
- blank_mask  output  DIGITS  leading-zero blank flags (only when LEADING_ZERO_BLANK_EN is defined; see Optional Feature).

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE, in_ready=1, out_valid=0, bcd_out=0, overflow=0, blank_mask=0.
  - Internal shift register, work BCD register and bit counter are all cleared.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture bin_in into the shift register, clear work BCD and its overflow bit, load counter=IN_WIDTH, go to SHIFT.
- SHIFT (in_ready=0), each edge:
  - Every work digit >=5 gets +3.
  - Then shift {work, shift_reg} left by 1; the shift_reg MSB enters digit 0 bit 0.
  - The bit shifted out of the top digit ORs into the internal overflow bit.
  - Decrement the counter. When the counter reaches 1 on this edge, go to DONE.
  - The add-3 check uses pre-shift digit values only. It is combinational within the same cycle.
- DONE (in_ready=0), one edge:
  - bcd_out <= work, overflow <= internal overflow bit, out_valid <= 1, go to IDLE.
- Latency: in_valid accepted at edge E; out_valid is high for exactly the cycle after edge E+IN_WIDTH+1.
- Throughput: one conversion every IN_WIDTH+2 cycles.
- out_valid is cleared on every edge where it is not being set.
- in_ready is high in the same cycle as out_valid, so back-to-back requests are accepted.
- in_valid while in_ready=0 is ignored, not queued. bin_in is only sampled at acceptance, so later changes do not affect an in-flight conversion.
- bcd_out and overflow hold their value between out_valid pulses.
- Reset mid-conversion: abort immediately to the reset values above. No out_valid is produced for the aborted value.
- Reset has priority over in_valid on the same edge.
- Overflow: when set, bcd_out holds the low DIGITS digits of the true decimal value. Not possible at the defaults (2^20-1 = 1048575 needs 7 digits).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - blank_mask is registered at the DONE edge alongside bcd_out.
  - Bit i=1 iff digit i and all higher digits are zero, with i>0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Reset value of blank_mask is 0.
- Not defined: blank_mask is tied to all zeros and no blanking logic is synthesized.

Test Plan:
- Reset, then bin_in=0 with in_valid for 1 cycle -> out_valid pulses exactly 22 cycles after the accept edge; bcd_out=28'h0000000; overflow=0.
- bin_in=255 -> bcd_out=28'h0000255. Then bin_in=1048575 -> bcd_out=28'h1048575, overflow=0.
- Sweep every result miniALU can produce: 0..15 + 0..15 and 0..15 * 0..15 (matching its select modes). Issue back-to-back (in_valid held high) -> each bcd_out decodes to the reference integer; accepts spaced every 22 cycles.
- Accept 1234, then assert in_valid with 9999 and change bin_in during SHIFT -> result 28'h0001234; 9999 is ignored; in_ready low for cycles 1..21.
- Assert reset 10 cycles into converting 500 -> next cycle in_ready=1, out_valid=0, bcd_out=0. A new 42 afterwards yields 28'h0000042.
- DIGITS=3 with bin_in=1000 -> bcd_out=12'h000, overflow=1. With LEADING_ZERO_BLANK_EN defined at defaults, bin_in=205 -> blank_mask=7'b1111000 and bin_in=0 -> blank_mask=7'b1111110.
